// File: rtl/apb3_master_arbiter.sv
// apb3_master_arbiter: round-robin sharing of one APB3 master port among NREQ
// requesters. Each transfer runs IDLE -> SETUP -> ACCESS, with PREADY wait
// states and an optional wait-state timeout that aborts the transfer with ERR.
module apb3_master_arbiter #(
    parameter int          NREQ    = 2,
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     HCLK,
    input  logic                     HRESETN,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NREQ-1:0]          REQ_WRITE,
    input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]          GNT,
    output logic [NREQ-1:0]          DONE,
    output logic [DATA_W-1:0]        RDATA,
    output logic                     ERR,
    output logic [ADDR_W-1:0]        PADDR,
    output logic                     PWRITE,
    output logic [DATA_W-1:0]        PWDATA,
    output logic                     PSEL,
    output logic                     PENABLE,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   last, last_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [NREQ-1:0]    gnt_n, done_n;
    logic [DATA_W-1:0]  rdata_n, pwdata_n;
    logic [ADDR_W-1:0]  paddr_n;
    logic               err_n, pwrite_n, psel_n, penable_n;

    // unpacked views of the packed request buses, indexed by requester
    logic [ADDR_W-1:0]  addr_arr  [NREQ];
    logic [DATA_W-1:0]  wdata_arr [NREQ];

    // arbitration scratch
    logic [NREQ-1:0]    eligible;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   pick;
    logic               pick_vld;

    // split the packed request buses into per-requester fields
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = REQ_ADDR[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = REQ_WDATA[i*DATA_W +: DATA_W];
        end
    end

    // round-robin pick: first eligible requester searching up from last+1;
    // a requester whose DONE is high this cycle is masked so a held REQ
    // is not re-granted for the transfer that just finished
    always_comb begin
        eligible = REQ & ~DONE;
        pick_vld = 1'b0;
        pick     = '0;
        sum      = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NREQ))
                sum = sum - (PTR_W+1)'(NREQ);
            cand = sum[PTR_W-1:0];
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // next-state and next-output logic for the APB phase sequencer
    always_comb begin
        state_n   = state;
        last_n    = last;
        cnt_n     = cnt;
        gnt_n     = GNT;
        done_n    = '0;
        rdata_n   = RDATA;
        err_n     = ERR;
        paddr_n   = PADDR;
        pwrite_n  = PWRITE;
        pwdata_n  = PWDATA;
        psel_n    = PSEL;
        penable_n = PENABLE;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_n     = S_SETUP;
                    last_n      = pick;
                    cnt_n       = '0;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                    psel_n      = 1'b1;
                    penable_n   = 1'b0;
                    paddr_n     = addr_arr[pick];
                    pwrite_n    = REQ_WRITE[pick];
                    pwdata_n    = REQ_WRITE[pick] ? wdata_arr[pick] : '0;
                end
            end
            S_SETUP: begin
                state_n   = S_ACCESS;
                penable_n = 1'b1;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    state_n   = S_IDLE;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    gnt_n     = '0;
                    done_n    = GNT;
                    rdata_n   = PWRITE ? '0 : PRDATA;
                    err_n     = PSLVERR;
                end else if ((TIMEOUT != 0) && (cnt == CNT_MAX)) begin
                    // stalled slave: abort with an error, no read data
                    state_n   = S_IDLE;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    gnt_n     = '0;
                    done_n    = GNT;
                    rdata_n   = '0;
                    err_n     = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                // unreachable encoding: recover to a quiet bus
                state_n   = S_IDLE;
                gnt_n     = '0;
                done_n    = '0;
                rdata_n   = '0;
                err_n     = 1'b0;
                paddr_n   = '0;
                pwrite_n  = 1'b0;
                pwdata_n  = '0;
                psel_n    = 1'b0;
                penable_n = 1'b0;
            end
        endcase
    end

    // state, pointer, wait counter and all registered outputs
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state   <= S_IDLE;
            last    <= PTR_W'(NREQ - 1);
            cnt     <= '0;
            GNT     <= '0;
            DONE    <= '0;
            RDATA   <= '0;
            ERR     <= 1'b0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            cnt     <= cnt_n;
            GNT     <= gnt_n;
            DONE    <= done_n;
            RDATA   <= rdata_n;
            ERR     <= err_n;
            PADDR   <= paddr_n;
            PWRITE  <= pwrite_n;
            PWDATA  <= pwdata_n;
            PSEL    <= psel_n;
            PENABLE <= penable_n;
        end
    end

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Directed bench for apb3_master_arbiter (NREQ=2, TIMEOUT=4): a per-cycle
// vector table plus hand sequences for request withdrawal and async reset.
module tb_apb3_master_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              HCLK = 1'b0;
    logic              HRESETN;
    logic [NREQ-1:0]   REQ;
    logic [NREQ*AW-1:0] REQ_ADDR;
    logic [NREQ-1:0]   REQ_WRITE;
    logic [NREQ*DW-1:0] REQ_WDATA;
    logic [NREQ-1:0]   GNT, DONE;
    logic [DW-1:0]     RDATA, PWDATA, PRDATA;
    logic              ERR, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [AW-1:0]     PADDR;

    int n_cmp = 0;
    int n_err = 0;

    apb3_master_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
        .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA), .GNT(GNT), .DONE(DONE),
        .RDATA(RDATA), .ERR(ERR), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  req;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        e_psel;
        logic        e_pen;
        logic [1:0]  e_gnt;
        logic [1:0]  e_done;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] req, input logic rdy, input logic serr,
                       input logic [31:0] prd, input logic psel, input logic pen,
                       input logic [1:0] gnt, input logic [1:0] done,
                       input logic err, input logic [31:0] rdata);
        vec_t v;
        v.req = req; v.pready = rdy; v.pslverr = serr; v.prdata = prd;
        v.e_psel = psel; v.e_pen = pen; v.e_gnt = gnt; v.e_done = done;
        v.e_err = err; v.e_rdata = rdata;
        tbl.push_back(v);
    endtask

    // advance one clock and settle past the edge
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESETN   = 1'b0;
        REQ       = '0;
        REQ_WRITE = 2'b01;                  // requester 0 writes, 1 reads
        REQ_ADDR  = {32'h0000_0080, 32'h0000_0040};
        REQ_WDATA = {32'hDEAD_BEEF, 32'hA5A5_0001};
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // req, rdy, serr, prdata | psel, pen, gnt, done, err, rdata
        // single write from requester 0
        add(2'b01, 1, 0, 32'h0,        1, 0, 2'b01, 2'b00, 0, 32'h0);
        add(2'b01, 1, 0, 32'h0,        1, 1, 2'b01, 2'b00, 0, 32'h0);
        add(2'b01, 1, 0, 32'hFFFF,     0, 0, 2'b00, 2'b01, 0, 32'h0);
        add(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0);
        // read from requester 1 with two wait states
        add(2'b10, 0, 0, 32'h0,        1, 0, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'h0,        1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'h0,        1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'h0,        1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 1, 0, 32'h12345678, 0, 0, 2'b00, 2'b10, 0, 32'h12345678);
        add(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h12345678);
        // both requesting: rotation 0,1,0,1
        add(2'b11, 1, 0, 32'h0,        1, 0, 2'b01, 2'b00, 0, 32'h12345678);
        add(2'b11, 1, 0, 32'h0,        1, 1, 2'b01, 2'b00, 0, 32'h12345678);
        add(2'b11, 1, 0, 32'h11,       0, 0, 2'b00, 2'b01, 0, 32'h0);
        add(2'b11, 1, 0, 32'h0,        1, 0, 2'b10, 2'b00, 0, 32'h0);
        add(2'b11, 1, 0, 32'h0,        1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b11, 1, 0, 32'h22,       0, 0, 2'b00, 2'b10, 0, 32'h22);
        add(2'b11, 1, 0, 32'h0,        1, 0, 2'b01, 2'b00, 0, 32'h22);
        add(2'b11, 1, 0, 32'h0,        1, 1, 2'b01, 2'b00, 0, 32'h22);
        add(2'b11, 1, 0, 32'h0,        0, 0, 2'b00, 2'b01, 0, 32'h0);
        add(2'b11, 1, 0, 32'h0,        1, 0, 2'b10, 2'b00, 0, 32'h0);
        add(2'b11, 1, 0, 32'h0,        1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b11, 1, 0, 32'h33,       0, 0, 2'b00, 2'b10, 0, 32'h33);
        add(2'b00, 1, 0, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h33);
        // slave error, then held REQ is masked for one cycle and re-granted
        add(2'b01, 1, 1, 32'h0,        1, 0, 2'b01, 2'b00, 0, 32'h33);
        add(2'b01, 1, 1, 32'h0,        1, 1, 2'b01, 2'b00, 0, 32'h33);
        add(2'b01, 1, 1, 32'h0,        0, 0, 2'b00, 2'b01, 1, 32'h0);
        add(2'b01, 1, 0, 32'h0,        0, 0, 2'b00, 2'b00, 1, 32'h0);
        add(2'b01, 1, 0, 32'h0,        1, 0, 2'b01, 2'b00, 1, 32'h0);
        add(2'b01, 1, 0, 32'h0,        1, 1, 2'b01, 2'b00, 1, 32'h0);
        add(2'b01, 1, 0, 32'h0,        0, 0, 2'b00, 2'b01, 0, 32'h0);
        add(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 0, 32'h0);
        // timeout: PREADY stuck low, 5 ACCESS cycles then abort
        add(2'b10, 0, 0, 32'hCAFE,     1, 0, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'hCAFE,     1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'hCAFE,     1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'hCAFE,     1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'hCAFE,     1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'hCAFE,     1, 1, 2'b10, 2'b00, 0, 32'h0);
        add(2'b10, 0, 0, 32'hCAFE,     0, 0, 2'b00, 2'b10, 1, 32'h0);
        add(2'b00, 0, 0, 32'h0,        0, 0, 2'b00, 2'b00, 1, 32'h0);

        // reset state
        #1;
        chk("rst psel", 64'(PSEL), 64'd0);
        chk("rst penable", 64'(PENABLE), 64'd0);
        chk("rst gnt", 64'(GNT), 64'd0);
        chk("rst done", 64'(DONE), 64'd0);
        chk("rst rdata", 64'(RDATA), 64'd0);
        chk("rst err", 64'(ERR), 64'd0);
        chk("rst paddr", 64'(PADDR), 64'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETN = 1'b1;

        // table: inputs apply for one cycle, outputs checked after the edge
        for (int i = 0; i < tbl.size(); i++) begin
            REQ     = tbl[i].req;
            PREADY  = tbl[i].pready;
            PSLVERR = tbl[i].pslverr;
            PRDATA  = tbl[i].prdata;
            step();
            chk($sformatf("v%0d psel", i),    64'(PSEL),    64'(tbl[i].e_psel));
            chk($sformatf("v%0d penable", i), 64'(PENABLE), 64'(tbl[i].e_pen));
            chk($sformatf("v%0d gnt", i),     64'(GNT),     64'(tbl[i].e_gnt));
            chk($sformatf("v%0d done", i),    64'(DONE),    64'(tbl[i].e_done));
            chk($sformatf("v%0d err", i),     64'(ERR),     64'(tbl[i].e_err));
            chk($sformatf("v%0d rdata", i),   64'(RDATA),   64'(tbl[i].e_rdata));
        end

        // request withdrawn in SETUP: latched fields hold, DONE still pulses
        REQ = 2'b01; PREADY = 1'b0; PRDATA = '0;
        step();
        chk("wd paddr", 64'(PADDR), 64'h40);
        chk("wd pwrite", 64'(PWRITE), 64'd1);
        chk("wd pwdata", 64'(PWDATA), 64'hA5A5_0001);
        chk("wd gnt", 64'(GNT), 64'b01);
        REQ = 2'b00;
        REQ_ADDR[31:0]  = 32'h99;
        REQ_WDATA[31:0] = 32'h0;
        step();
        chk("wd access pen", 64'(PENABLE), 64'd1);
        chk("wd access paddr", 64'(PADDR), 64'h40);
        chk("wd access pwdata", 64'(PWDATA), 64'hA5A5_0001);
        PREADY = 1'b1;
        step();
        chk("wd done", 64'(DONE), 64'b01);
        chk("wd err", 64'(ERR), 64'd0);
        PREADY = 1'b0;
        step();
        chk("wd idle psel", 64'(PSEL), 64'd0);

        // reset mid-ACCESS after a grant to requester 0 (pointer then = 0)
        REQ = 2'b01; REQ_WRITE = 2'b00; REQ_WDATA[31:0] = 32'h5555;
        step();
        chk("rd pwrite", 64'(PWRITE), 64'd0);
        chk("rd pwdata", 64'(PWDATA), 64'd0);
        chk("rd paddr", 64'(PADDR), 64'h99);
        step();
        chk("rd access pen", 64'(PENABLE), 64'd1);
        step();
        chk("rd wait psel", 64'(PSEL), 64'd1);
        #2;
        HRESETN = 1'b0;
        #1;
        chk("arst psel", 64'(PSEL), 64'd0);
        chk("arst penable", 64'(PENABLE), 64'd0);
        chk("arst gnt", 64'(GNT), 64'd0);
        chk("arst done", 64'(DONE), 64'd0);
        PREADY = 1'b1;
        step();
        chk("arst held done", 64'(DONE), 64'd0);
        HRESETN = 1'b1;
        REQ = 2'b11;
        step();
        chk("ptr reset gnt", 64'(GNT), 64'b01);
        step();
        step();
        chk("ptr reset done", 64'(DONE), 64'b01);
        step();
        chk("ptr next gnt", 64'(GNT), 64'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb3_master_arbiter.md
# apb3_master_arbiter

Shares a single APB3 master port between NREQ internal requesters and sequences each transfer through the APB3 SETUP and ACCESS phases. Arbitration is round-robin. Wait states are driven by PREADY, and a bounded timeout aborts transfers that stall. The block sits between the bridge/register-access front ends and the APB3 peripheral bus, and is the sole driver of PSEL, PENABLE, PADDR, PWRITE and PWDATA.

## Interface
- NREQ, 2: number of requesters (2..8)
- ADDR_W, 32: APB address width
- DATA_W, 32: APB data width
- TIMEOUT, 255: max ACCESS wait cycles before abort (0 = never abort)

- HCLK  in  1  clock, all logic rising-edge
- HRESETN  in  1  asynchronous active-low reset
- REQ  in  NREQ  per-requester request level, held until its DONE
- REQ_ADDR  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- REQ_WRITE  in  NREQ  1 = write, 0 = read
- REQ_WDATA  in  NREQ*DATA_W  packed write data
- GNT  out  NREQ  one-hot owner, high from SETUP through the last ACCESS cycle
- DONE  out  NREQ  one-cycle completion pulse to the owner
- RDATA  out  DATA_W  read data, valid with DONE (0 for writes and aborts)
- ERR  out  1  valid with DONE: PSLVERR or timeout
- PADDR  out  ADDR_W
- PWRITE  out  1
- PWDATA  out  DATA_W
- PSEL  out  1
- PENABLE  out  1
- PRDATA  in  DATA_W
- PREADY  in  1
- PSLVERR  in  1

## Operation
- All outputs are registered. Reset value of every output is 0. The state resets to IDLE, the round-robin pointer to "last = NREQ-1" (so requester 0 has top priority), and the wait counter to 0.
- States are IDLE, SETUP and ACCESS. Encoding 2'b11 is illegal and returns to IDLE with all outputs 0.
- IDLE:
  - If (REQ & ~DONE) != 0, select the first set bit searching upward from last+1, wrapping modulo NREQ.
  - Latch that requester's addr, write and wdata onto PADDR, PWRITE and PWDATA (PWDATA = 0 for reads).
  - Set PSEL=1 and GNT=onehot(i), update last=i, and go to SETUP.
- SETUP: PENABLE=1, then go to ACCESS. This phase is unconditional and lasts exactly one cycle.
- ACCESS, on each cycle:
  - If PREADY=1: go to IDLE and set PSEL, PENABLE and GNT to 0. Pulse DONE[i]. Set RDATA=PRDATA if read, else 0. Set ERR=PSLVERR.
  - Else if TIMEOUT!=0 and wait count == TIMEOUT: go to IDLE and set PSEL, PENABLE and GNT to 0. Pulse DONE[i] with ERR=1 and RDATA=0.
  - Else: increment the wait count and hold all APB outputs stable.
- The wait count clears on entry to SETUP. Its width is clog2(TIMEOUT+1), minimum 1 bit.
- A requester's REQ is masked in the cycle its DONE is high, so a held REQ is not re-granted by mistake. A requester wanting back-to-back transfers keeps REQ high and is re-arbitrated from the next IDLE cycle.
- Deasserting REQ or changing REQ_* after grant has no effect. The transfer completes and DONE still pulses.
- RDATA and ERR hold their values until the next DONE.

## Timing
- If REQ rises with the block idle in cycle N, PSEL=1 in N+1 (SETUP) and PENABLE=1 in N+2 (ACCESS).
- With PREADY=1 in N+2, DONE is high in N+3, together with the IDLE state. Minimum period is 3 cycles per transfer.
- k wait states add k cycles.
- A timeout fires on the ACCESS cycle where the count equals TIMEOUT: TIMEOUT+1 ACCESS cycles in total. DONE follows on the next cycle.
- Simultaneous requests are granted in rotation, one per ≥3 cycles. No requester waits more than NREQ-1 transfers.
- HRESETN low at any point, including mid-ACCESS, forces all outputs to 0 asynchronously. The in-flight transfer is dropped with no DONE.

## Test plan
- Single write: REQ[0]=1, addr 0x40, wdata 0xA5A5_0001, PREADY=1 always.
  - Required: PSEL in N+1, PENABLE in N+2, DONE[0] in N+3, ERR=0, RDATA=0.
- Read with 2 wait states: PREADY low for 2 ACCESS cycles, PRDATA=0x1234_5678.
  - Required: DONE[1] 5 cycles after REQ, RDATA=0x1234_5678.
- Arbitration: REQ=2'b11 held continuously with PREADY=1.
  - Required: grants alternate 0,1,0,1. GNT stays one-hot. DONE pulses one cycle each, 3 cycles apart.
- Error and timeout: PSLVERR=1 with PREADY=1.
  - Required: ERR=1.
  - Then TIMEOUT=4 with PREADY stuck at 0: exactly 5 ACCESS cycles, then DONE with ERR=1 and RDATA=0. PSEL and PENABLE are 0 afterward.
- Reset mid-ACCESS: drop HRESETN during a wait state.
  - Required: PSEL, PENABLE, GNT and DONE are 0 immediately.
  - After release, REQ[1] is granted before REQ[0] only if REQ[0] is low (pointer reset check).
- Request withdrawn: REQ[0] drops in SETUP.
  - Required: the transfer still completes and DONE[0] pulses.
